exception_unit: RTL and testbench

Commit-point exception and interrupt arbiter that sits directly upstream of the COP0 register file. It collects per-instruction exception flags from the MEM/commit stage and synchronises external hardware interrupts. It picks the single highest-priority event and drives the COP0 exception write port (`exp_*`), the pipeline flush, and the PC redirect to the exception vector or to EPC on `eret`. After each redirect it blanks commit for a fixed drain window so flushed bubbles cannot raise events.

---
 rtl/exception_unit_if.sv | 45 ++++
 rtl/exception_unit.sv | 146 ++++++++++++++
 tb/tb_exception_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/exception_unit_if.sv
// Commit-stage and COP0 bundle between the pipeline, COP0 and exception_unit.
// The slave modport is the exception unit's view; master is the surrounding pipeline/COP0.
interface exception_unit_if;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic        mem_bd;
   logic        mem_eret;
   logic        mem_adel_if;
   logic        mem_ri;
   logic        mem_ov;
   logic        mem_sys;
   logic        mem_bp;
   logic        mem_adel_ld;
   logic        mem_ades;
   logic [31:0] mem_badvaddr;
   logic        allow_interrupt;
   logic [7:0]  interrupt_flag;
   logic [31:0] epc_address;

   logic        exp_en;
   logic        exp_badvaddr_en;
   logic        exp_bd;
   logic [4:0]  exp_code;
   logic [31:0] exp_badvaddr;
   logic [31:0] exp_epc;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport slave (
      input  mem_valid, mem_pc, mem_bd, mem_eret, mem_adel_if, mem_ri, mem_ov,
             mem_sys, mem_bp, mem_adel_ld, mem_ades, mem_badvaddr,
             allow_interrupt, interrupt_flag, epc_address,
      output exp_en, exp_badvaddr_en, exp_bd, exp_code, exp_badvaddr, exp_epc,
             flush, redirect_valid, redirect_pc
   );

   modport master (
      output mem_valid, mem_pc, mem_bd, mem_eret, mem_adel_if, mem_ri, mem_ov,
             mem_sys, mem_bp, mem_adel_ld, mem_ades, mem_badvaddr,
             allow_interrupt, interrupt_flag, epc_address,
      input  exp_en, exp_badvaddr_en, exp_bd, exp_code, exp_badvaddr, exp_epc,
             flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/exception_unit.sv
// Commit-point exception/interrupt arbiter: picks the highest-priority event, pulses the
// COP0 write port, flush and PC redirect for one cycle, then blanks commit for a drain window.
module exception_unit #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int          DRAIN_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           hw_int,
   output logic [5:0]           int_pending,
   exception_unit_if.slave      bus
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [5:0]  int_sync;
   logic        int_req;
   logic [31:0] epc_value;

   logic        exp_en_d, exp_badvaddr_en_d, exp_bd_d, flush_d, redirect_valid_d;
   logic [4:0]  exp_code_d;
   logic [31:0] exp_badvaddr_d, exp_epc_d, redirect_pc_d;
   logic        take, is_exc;
   logic        unused_flag_bits;

   assign unused_flag_bits = ^bus.interrupt_flag[1:0];
   assign int_req   = bus.allow_interrupt & |(int_pending & bus.interrupt_flag[7:2]);
   assign epc_value = bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_sync    <= '0;
         int_pending <= '0;
      end else begin
         int_sync    <= hw_int;
         int_pending <= int_sync;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next        = state;
      cnt_next          = cnt;
      exp_en_d          = 1'b0;
      exp_badvaddr_en_d = 1'b0;
      exp_bd_d          = 1'b0;
      exp_code_d        = 5'h00;
      exp_badvaddr_d    = 32'h0;
      exp_epc_d         = 32'h0;
      flush_d           = 1'b0;
      redirect_valid_d  = 1'b0;
      redirect_pc_d     = 32'h0;
      take              = 1'b0;
      is_exc            = 1'b0;

      case (state)
         IDLE: begin
            if (bus.mem_valid) begin
               is_exc = 1'b1;
               if (int_req)                exp_code_d = 5'h00;
               else if (bus.mem_adel_if) begin
                  exp_code_d        = 5'h04;
                  exp_badvaddr_en_d = 1'b1;
                  exp_badvaddr_d    = bus.mem_pc;
               end
               else if (bus.mem_ri)        exp_code_d = 5'h0A;
               else if (bus.mem_ov)        exp_code_d = 5'h0C;
               else if (bus.mem_sys)       exp_code_d = 5'h08;
               else if (bus.mem_bp)        exp_code_d = 5'h09;
               else if (bus.mem_adel_ld) begin
                  exp_code_d        = 5'h04;
                  exp_badvaddr_en_d = 1'b1;
                  exp_badvaddr_d    = bus.mem_badvaddr;
               end
               else if (bus.mem_ades) begin
                  exp_code_d        = 5'h05;
                  exp_badvaddr_en_d = 1'b1;
                  exp_badvaddr_d    = bus.mem_badvaddr;
               end
               else                        is_exc = 1'b0;

               take = is_exc | bus.mem_eret;
            end

            if (take) begin
               flush_d          = 1'b1;
               redirect_valid_d = 1'b1;
               state_next       = DRAIN;
               cnt_next         = 4'(DRAIN_CYCLES);
            end

            // An exception on the ERET itself takes the vector; a clean ERET returns to EPC.
            if (is_exc) begin
               exp_en_d      = 1'b1;
               exp_epc_d     = epc_value;
               exp_bd_d      = bus.mem_bd;
               redirect_pc_d = EXC_VECTOR;
            end else if (take) begin
               redirect_pc_d = bus.epc_address;
            end else begin
               exp_code_d = 5'h00;
            end
         end

         DRAIN: begin
            cnt_next = cnt - 4'd1;
            if (cnt <= 4'd1) state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   // All outputs are single-cycle pulses: they reload from the decision each cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         cnt                 <= '0;
         bus.exp_en          <= 1'b0;
         bus.exp_badvaddr_en <= 1'b0;
         bus.exp_bd          <= 1'b0;
         bus.exp_code        <= 5'h00;
         bus.exp_badvaddr    <= 32'h0;
         bus.exp_epc         <= 32'h0;
         bus.flush           <= 1'b0;
         bus.redirect_valid  <= 1'b0;
         bus.redirect_pc     <= 32'h0;
      end else begin
         state               <= state_next;
         cnt                 <= cnt_next;
         bus.exp_en          <= exp_en_d;
         bus.exp_badvaddr_en <= exp_badvaddr_en_d;
         bus.exp_bd          <= exp_bd_d;
         bus.exp_code        <= exp_code_d;
         bus.exp_badvaddr    <= exp_badvaddr_d;
         bus.exp_epc         <= exp_epc_d;
         bus.flush           <= flush_d;
         bus.redirect_valid  <= redirect_valid_d;
         bus.redirect_pc     <= redirect_pc_d;
      end
   end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: priority, delay-slot EPC, drain window,
// interrupt synchroniser latency, ERET redirect and asynchronous reset.
module tb_exception_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] hw_int = '0;
   logic [5:0] int_pending;
   int         checks = 0;
   int         errors = 0;

   exception_unit_if bus ();

   exception_unit #(.EXC_VECTOR(32'hBFC0_0380), .DRAIN_CYCLES(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .hw_int      (hw_int),
      .int_pending (int_pending),
      .bus         (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      bus.mem_valid = 0; bus.mem_pc = '0; bus.mem_bd = 0; bus.mem_eret = 0;
      bus.mem_adel_if = 0; bus.mem_ri = 0; bus.mem_ov = 0; bus.mem_sys = 0;
      bus.mem_bp = 0; bus.mem_adel_ld = 0; bus.mem_ades = 0; bus.mem_badvaddr = '0;
      bus.allow_interrupt = 0; bus.interrupt_flag = '0; bus.epc_address = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      clear_inputs();
      repeat (4) step();
   endtask

   task automatic test_reset();
      clear_inputs();
      #12;
      checks++; if (bus.exp_en !== 1'b0) begin errors++; $display("FAIL reset_exp_en got=%b exp=0", bus.exp_en); end
      checks++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_flush_redirect got=%b%b exp=00", bus.flush, bus.redirect_valid); end
      checks++; if (bus.redirect_pc !== 32'h0 || bus.exp_epc !== 32'h0) begin errors++; $display("FAIL reset_data got pc=%h epc=%h exp=0", bus.redirect_pc, bus.exp_epc); end
      checks++; if (int_pending !== 6'h0) begin errors++; $display("FAIL reset_int_pending got=%h exp=0", int_pending); end
      @(negedge clk); rst = 1;
      step();
   endtask

   task automatic test_overflow();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0100; bus.mem_ov = 1;
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h0C) begin errors++; $display("FAIL ov_code got en=%b code=%h exp en=1 code=0c", bus.exp_en, bus.exp_code); end
      checks++; if (bus.exp_epc !== 32'h8000_0100 || bus.exp_bd !== 1'b0) begin errors++; $display("FAIL ov_epc got=%h bd=%b exp=80000100 bd=0", bus.exp_epc, bus.exp_bd); end
      checks++; if (bus.exp_badvaddr_en !== 1'b0) begin errors++; $display("FAIL ov_bva_en got=%b exp=0", bus.exp_badvaddr_en); end
      checks++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL ov_redirect got flush=%b rv=%b pc=%h exp 1 1 bfc00380", bus.flush, bus.redirect_valid, bus.redirect_pc); end
      // Second mem_ov stays asserted: ignored for the three drain cycles.
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.exp_en !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL ov_drain%0d got en=%b flush=%b pc=%h exp 0 0 0", i, bus.exp_en, bus.flush, bus.redirect_pc); end
      end
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h0C) begin errors++; $display("FAIL ov_after_drain got en=%b code=%h exp 1 0c", bus.exp_en, bus.exp_code); end
      idle_gap();
   endtask

   task automatic test_delay_slot();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0204; bus.mem_bd = 1;
      bus.mem_ades = 1; bus.mem_badvaddr = 32'h1234_5671;
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h05) begin errors++; $display("FAIL ds_code got en=%b code=%h exp 1 05", bus.exp_en, bus.exp_code); end
      checks++; if (bus.exp_epc !== 32'h8000_0200 || bus.exp_bd !== 1'b1) begin errors++; $display("FAIL ds_epc got=%h bd=%b exp=80000200 bd=1", bus.exp_epc, bus.exp_bd); end
      checks++; if (bus.exp_badvaddr_en !== 1'b1 || bus.exp_badvaddr !== 32'h1234_5671) begin errors++; $display("FAIL ds_bva got en=%b bva=%h exp 1 12345671", bus.exp_badvaddr_en, bus.exp_badvaddr); end
      idle_gap();
   endtask

   task automatic test_priority();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0300; bus.mem_badvaddr = 32'hDEAD_0000;
      bus.mem_adel_if = 1; bus.mem_ri = 1; bus.mem_adel_ld = 1;
      step();
      checks++; if (bus.exp_code !== 5'h04 || bus.exp_badvaddr !== 32'h8000_0300 || bus.exp_badvaddr_en !== 1'b1) begin errors++; $display("FAIL prio_adel_if got code=%h bva=%h en=%b exp 04 80000300 1", bus.exp_code, bus.exp_badvaddr, bus.exp_badvaddr_en); end
      idle_gap();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0310; bus.mem_eret = 1; bus.mem_sys = 1;
      bus.epc_address = 32'h8000_0040;
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h08) begin errors++; $display("FAIL prio_eret_sys got en=%b code=%h exp 1 08", bus.exp_en, bus.exp_code); end
      checks++; if (bus.redirect_pc !== 32'hBFC0_0380 || bus.exp_badvaddr_en !== 1'b0) begin errors++; $display("FAIL prio_eret_sys_pc got pc=%h bva_en=%b exp bfc00380 0", bus.redirect_pc, bus.exp_badvaddr_en); end
      idle_gap();
   endtask

   task automatic test_eret();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0500; bus.mem_eret = 1;
      bus.epc_address = 32'h8000_0040;
      step();
      checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h8000_0040) begin errors++; $display("FAIL eret_redirect got rv=%b pc=%h exp 1 80000040", bus.redirect_valid, bus.redirect_pc); end
      checks++; if (bus.flush !== 1'b1 || bus.exp_en !== 1'b0) begin errors++; $display("FAIL eret_flush got flush=%b en=%b exp 1 0", bus.flush, bus.exp_en); end
      idle_gap();
   endtask

   task automatic test_interrupt();
      bus.allow_interrupt = 1; bus.interrupt_flag = 8'h04;
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0400;
      hw_int = 6'b000001;
      step();
      checks++; if (bus.exp_en !== 1'b0 || int_pending !== 6'h00) begin errors++; $display("FAIL int_edge1 got en=%b pend=%h exp 0 00", bus.exp_en, int_pending); end
      step();
      checks++; if (bus.exp_en !== 1'b0 || int_pending !== 6'h01) begin errors++; $display("FAIL int_edge2 got en=%b pend=%h exp 0 01", bus.exp_en, int_pending); end
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h00 || bus.exp_epc !== 32'h8000_0400) begin errors++; $display("FAIL int_taken got en=%b code=%h epc=%h exp 1 00 80000400", bus.exp_en, bus.exp_code, bus.exp_epc); end
      checks++; if (bus.redirect_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL int_redirect got=%h exp=bfc00380", bus.redirect_pc); end
      hw_int = '0;
      idle_gap();
   endtask

   task automatic test_int_masked();
      bus.allow_interrupt = 1; bus.interrupt_flag = 8'h00;
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0600;
      hw_int = 6'b000001;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.exp_en !== 1'b0) begin errors++; $display("FAIL int_masked%0d got en=%b exp 0", i, bus.exp_en); end
      end
      checks++; if (int_pending[0] !== 1'b1) begin errors++; $display("FAIL int_masked_pending got=%b exp=1", int_pending[0]); end
      // Enabled interrupt but no valid commit: still no event.
      bus.interrupt_flag = 8'h04; bus.mem_valid = 0;
      repeat (3) step();
      checks++; if (bus.exp_en !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL int_no_valid got en=%b flush=%b exp 0 0", bus.exp_en, bus.flush); end
      hw_int = '0;
      idle_gap();
   endtask

   task automatic test_reset_drain();
      bus.mem_valid = 1; bus.mem_pc = 32'h8000_0700; bus.mem_sys = 1;
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h08) begin errors++; $display("FAIL rst_pre got en=%b code=%h exp 1 08", bus.exp_en, bus.exp_code); end
      #2 rst = 0;
      #1;
      checks++; if (bus.exp_en !== 1'b0 || bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.exp_code !== 5'h0) begin errors++; $display("FAIL rst_async got en=%b flush=%b rv=%b pc=%h code=%h exp all 0", bus.exp_en, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.exp_code); end
      @(negedge clk); rst = 1;
      step();
      checks++; if (bus.exp_en !== 1'b1 || bus.exp_code !== 5'h08 || bus.exp_epc !== 32'h8000_0700) begin errors++; $display("FAIL rst_first_commit got en=%b code=%h epc=%h exp 1 08 80000700", bus.exp_en, bus.exp_code, bus.exp_epc); end
      idle_gap();
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_delay_slot();
      test_priority();
      test_eret();
      test_interrupt();
      test_int_masked();
      test_reset_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
